// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side write signals of the arbiter, bundled as one bus.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;

  modport master (
    output req_valid, req_data, req_last, fifo_wr_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_wr_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from
// i_rr_ptr+1, wrapping explicitly at NUM_REQ.
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_req[wrap_idx(i_rr_ptr, k)]) begin
        o_idx   = wrap_idx(i_rr_ptr, k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin locked-burst arbiter for the FIFO write port (wr_clk domain).
// Optional per-requester beat counters: define FIFO_WR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// BURST | grant_id owns the write port until last beat or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                     wr_clk,
  input  logic                     wr_rstn,
  fifo_wr_arbiter_if.slave         bus,
  output logic [id_w(NUM_REQ)-1:0] grant_id,
  output logic                     busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats
`endif
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = cnt_w(MAX_BURST);

  arb_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_grant, w_grant_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  w_pick;
  logic             w_found;
  logic             w_beat;
  logic             w_busy;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req    (bus.req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_pick),
    .o_found  (w_found)
  );

  // rr_ptr starts at the top so requester 0 wins the first arbitration.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_cnt_nxt        = r_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_busy           = 1'b0;
    w_beat           = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_busy                 = 1'b1;
        bus.req_ready[r_grant] = ~bus.fifo_wr_full;
        bus.fifo_wr_data       = bus.req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
        w_beat                 = bus.req_valid[r_grant] & ~bus.fifo_wr_full;
        bus.fifo_wr_en         = w_beat;
        if (w_beat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (bus.req_last[r_grant] || (r_cnt == CNT_W'(MAX_BURST - 1))) begin
            w_rr_ptr_nxt = r_grant;
            w_state_nxt  = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = w_busy;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [NUM_REQ];

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)
          r_stat[i] <= '0;
        else if (w_beat && (r_grant == ID_W'(i)) && (r_stat[i] != '1))
          r_stat[i] <= r_stat[i] + STAT_W'(1);
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_beats[i*STAT_W +: STAT_W] = r_stat[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester model, write log, hand-computed expectations.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic       wr_clk;
  logic       wr_rstn;
  logic [1:0] grant_id;
  logic       busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic          stat_clr;
  logic [NR*16-1:0] stat_beats;
`endif

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (16)
  ) dut (
    .wr_clk   (wr_clk),
    .wr_rstn  (wr_rstn),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_beats (stat_beats)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          rem [NR];
  logic [7:0]  nxt [NR];
  logic [NR-1:0] hold;
  logic [NR-1:0] last_every;

  int lg_id [$];
  int lg_data [$];
  int lg_cyc [$];

  logic       pend;
  logic [1:0] pend_id;

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = (rem[i] > 0) && !hold[i];
      bus.req_last[i]          = (rem[i] == 1) || last_every[i];
      bus.req_data[i*DW +: DW] = nxt[i];
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #2;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rem[i];
    return s;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (((pending() > 0) || busy) && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, pending(), 0);
  endtask

  task automatic wait_beats(input string tag, input int cnt, input int budget);
    int n = 0;
    while ((lg_id.size() < cnt) && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_reached"}, lg_id.size(), cnt);
  endtask

  task automatic clear_log();
    lg_id.delete();
    lg_data.delete();
    lg_cyc.delete();
  endtask

  // Requester model: a beat seen at negedge commits on the following posedge.
  initial begin
    pend    = 1'b0;
    pend_id = '0;
    forever begin
      @(negedge wr_clk);
      pend    = bus.fifo_wr_en;
      pend_id = grant_id;
      if (pend) begin
        lg_id.push_back(int'(grant_id));
        lg_data.push_back(int'(bus.fifo_wr_data));
        lg_cyc.push_back(cyc);
      end
      @(posedge wr_clk);
      #1;
      if (pend && wr_rstn) begin
        rem[pend_id] = rem[pend_id] - 1;
        nxt[pend_id] = nxt[pend_id] + 8'd1;
      end
      drive();
    end
  end

  initial begin
    wr_rstn          = 1'b0;
    bus.fifo_wr_full = 1'b0;
    bus.req_valid    = '0;
    bus.req_last     = '0;
    bus.req_data     = '0;
    hold             = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // reset priority: all valid, every beat is last
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    nxt[0] = 8'h00; nxt[1] = 8'h10; nxt[2] = 8'h20; nxt[3] = 8'h30;
    last_every = 4'hF;
    drive();
    repeat (2) @(negedge wr_clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_grant", grant_id, 0);
    step();
    wr_rstn = 1'b1;
    @(negedge wr_clk);
    chk("lat_idle_busy", busy, 0);
    @(negedge wr_clk);
    chk("lat_busy", busy, 1);
    chk("lat_ready", bus.req_ready, 4'b0001);
    chk("lat_wr_en", bus.fifo_wr_en, 1);
    wait_done("prio", 60);
    chk("prio_count", lg_id.size(), 5);
    if (lg_id.size() == 5) begin
      chk("prio_id0", lg_id[0], 0);
      chk("prio_id1", lg_id[1], 1);
      chk("prio_id2", lg_id[2], 2);
      chk("prio_id3", lg_id[3], 3);
      chk("prio_id4", lg_id[4], 0);
      chk("prio_data0", lg_data[0], 8'h00);
      chk("prio_data3", lg_data[3], 8'h30);
      chk("prio_data4", lg_data[4], 8'h01);
      for (int k = 1; k < 5; k++) chk($sformatf("prio_gap%0d", k), lg_cyc[k] - lg_cyc[k-1], 2);
    end

    // burst cap: 20-beat packet splits 16 + 4
    last_every = '0;
    clear_log();
    step();
    rem[2] = 20; nxt[2] = 8'h20;
    drive();
    wait_done("cap", 100);
    chk("cap_count", lg_id.size(), 20);
    if (lg_id.size() == 20) begin
      for (int k = 0; k < 20; k++) begin
        chk($sformatf("cap_id%0d", k), lg_id[k], 2);
        chk($sformatf("cap_data%0d", k), lg_data[k], 8'h20 + k);
      end
      chk("cap_gap15", lg_cyc[15] - lg_cyc[14], 1);
      chk("cap_gap16", lg_cyc[16] - lg_cyc[15], 2);
    end

    // full stall of 5 cycles after the 3rd beat of an 18-beat packet
    clear_log();
    step();
    rem[1] = 18; nxt[1] = 8'h40;
    drive();
    wait_beats("stall", 3, 20);
    bus.fifo_wr_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wr_clk);
      chk($sformatf("stall_en%0d", k), bus.fifo_wr_en, 0);
      chk($sformatf("stall_ready%0d", k), bus.req_ready, 0);
      chk($sformatf("stall_busy%0d", k), busy, 1);
      @(posedge wr_clk);
      #2;
    end
    bus.fifo_wr_full = 1'b0;
    wait_done("stall", 100);
    chk("stall_count", lg_id.size(), 18);
    if (lg_id.size() == 18) begin
      for (int k = 0; k < 18; k++) begin
        chk($sformatf("stall_id%0d", k), lg_id[k], 1);
        chk($sformatf("stall_data%0d", k), lg_data[k], 8'h40 + k);
      end
      chk("stall_gap3", lg_cyc[3] - lg_cyc[2], 6);
      chk("stall_gap15", lg_cyc[15] - lg_cyc[14], 1);
      chk("stall_gap16", lg_cyc[16] - lg_cyc[15], 2);
    end

    // lock: owner 2 pauses 3 cycles while 3 and 0 wait
    clear_log();
    step();
    rem[2] = 6; rem[3] = 1; rem[0] = 1;
    drive();
    wait_beats("lock", 2, 20);
    hold[2] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      @(negedge wr_clk);
      chk($sformatf("lock_grant%0d", k), grant_id, 2);
      chk($sformatf("lock_en%0d", k), bus.fifo_wr_en, 0);
      chk($sformatf("lock_ready%0d", k), bus.req_ready, 4'b0100);
      @(posedge wr_clk);
      #2;
    end
    hold[2] = 1'b0;
    drive();
    wait_done("lock", 60);
    chk("lock_count", lg_id.size(), 8);
    if (lg_id.size() == 8) begin
      for (int k = 0; k < 6; k++) chk($sformatf("lock_id%0d", k), lg_id[k], 2);
      chk("lock_next", lg_id[6], 3);
      chk("lock_after", lg_id[7], 0);
    end

    // async reset on the 3rd beat
    clear_log();
    step();
    rem[3] = 8; nxt[3] = 8'h60;
    drive();
    wait_beats("arst", 2, 20);
    @(negedge wr_clk);
    chk("arst_pre_en", bus.fifo_wr_en, 1);
    #1 wr_rstn = 1'b0;
    #1;
    chk("arst_en", bus.fifo_wr_en, 0);
    chk("arst_ready", bus.req_ready, 0);
    chk("arst_busy", busy, 0);
    step();
    chk("arst_grant", grant_id, 0);
    chk("arst_rem3", rem[3], 6);
    rem[0] = 1; rem[1] = 1;
    drive();
    clear_log();
    step();
    wr_rstn = 1'b1;
    wait_done("arst", 80);
    chk("arst_count", lg_id.size(), 8);
    if (lg_id.size() == 8) begin
      chk("arst_first", lg_id[0], 0);
      chk("arst_second", lg_id[1], 1);
      chk("arst_third", lg_id[2], 3);
      chk("arst_resume", lg_data[2], 8'h62);
    end

`ifdef FIFO_WR_ARB_STATS_EN
    clear_log();
    step();
    rem[1] = 70000;
    drive();
    wait_done("stats", 80000);
    clear_log();
    @(negedge wr_clk);
    chk("stats_sat1", stat_beats[31:16], 16'hFFFF);
    chk("stats_req0", stat_beats[15:0], 16'd1);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge wr_clk);
    chk("stats_clr1", stat_beats[31:16], 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
